// File: rtl/line_scheduler.sv
// Picks the next row/column for the nonogram line solver: round-robin over dirty, unsolved lines.
// Optional LINE_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYCLES); without it timeout_err is tied 0.
module line_scheduler #(
    parameter int MAX_ROWS       = 11,
    parameter int MAX_COLS       = 11,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [$clog2(MAX_ROWS)-1:0]                  num_rows,
    input  logic [$clog2(MAX_COLS)-1:0]                  num_cols,
    output logic                                         line_valid,
    input  logic                                         line_ready,
    output logic [$clog2(MAX_ROWS+MAX_COLS)-1:0]         line_idx,
    output logic                                         line_is_row,
    input  logic                                         done_valid,
    input  logic [((MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS)-1:0] done_changed,
    input  logic                                         done_line_solved,
    output logic                                         busy,
    output logic                                         complete,
    output logic                                         stalled,
    output logic [15:0]                                  issue_count,
    output logic                                         timeout_err
);
    localparam int NL = MAX_ROWS + MAX_COLS;
    localparam int IW = $clog2(NL);
    localparam int TW = IW + 1;
    localparam int RW = $clog2(MAX_ROWS);
    localparam int CW = $clog2(MAX_COLS);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT} state_t;

    state_t          state;
    logic [RW-1:0]   rows_q;
    logic [CW-1:0]   cols_q;
    logic [NL-1:0]   dirty;
    logic [NL-1:0]   solved;
    logic [IW-1:0]   ptr;

    logic [TW-1:0]   total;
    logic [TW-1:0]   total_in;
    logic [NL-1:0]   active;
    logic [NL-1:0]   active_in;
    logic [NL-1:0]   cand;
    logic [2*NL-1:0] ext;
    logic [NL-1:0]   win;
    logic            found;
    logic [IW-1:0]   off;
    logic [TW-1:0]   sum;
    logic [IW-1:0]   pick;
    logic            all_solved;
    logic [NL-1:0]   idx_onehot;
    logic [NL-1:0]   set_mask;
    logic [TW-1:0]   ptr_next;
    logic            timeout_hit;

    assign total     = TW'(rows_q) + TW'(cols_q);
    assign total_in  = TW'(num_rows) + TW'(num_cols);
    assign active    = ~({NL{1'b1}} << total);
    assign active_in = ~({NL{1'b1}} << total_in);
    assign cand      = dirty & ~solved & active;
    assign all_solved = ((solved & active) == active);

    // Duplicate the candidate vector above bit 'total' so a plain right shift by ptr
    // yields the rotation that wraps at the active line count rather than at NL.
    assign ext = {{NL{1'b0}}, cand} | ({{NL{1'b0}}, cand} << total);
    assign win = NL'(ext >> ptr);

    always_comb begin
        found = |win;
        off   = '0;
        for (int k = NL - 1; k >= 0; k--) begin
            if (win[k]) off = IW'(k);
        end
        sum  = TW'(ptr) + TW'(off);
        pick = (sum >= total) ? IW'(sum - total) : IW'(sum);
    end

    assign idx_onehot = NL'(1) << line_idx;
    assign ptr_next   = TW'(line_idx) + TW'(1);

    // A row's changed cells dirty the crossing columns (offset by rows), and vice versa.
    always_comb begin
        set_mask = '0;
        if (line_is_row)
            set_mask = NL'(done_changed[MAX_COLS-1:0] & ~({MAX_COLS{1'b1}} << cols_q)) << rows_q;
        else
            set_mask = NL'(done_changed[MAX_ROWS-1:0] & ~({MAX_ROWS{1'b1}} << rows_q));
    end

`ifdef LINE_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMW-1:0] tmr;

    assign timeout_hit = (state == WAIT) && !done_valid && (tmr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && start)
                timeout_err <= 1'b0;
            if (state == ISSUE)
                tmr <= TMW'(TIMEOUT_CYCLES - 1);
            else if (state == WAIT && tmr != '0)
                tmr <= tmr - TMW'(1);
            if (timeout_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            dirty       <= '0;
            solved      <= '0;
            ptr         <= '0;
            line_valid  <= 1'b0;
            line_idx    <= '0;
            line_is_row <= 1'b0;
            busy        <= 1'b0;
            complete    <= 1'b0;
            stalled     <= 1'b0;
            issue_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q      <= num_rows;
                        cols_q      <= num_cols;
                        dirty       <= active_in;
                        solved      <= '0;
                        ptr         <= '0;
                        complete    <= 1'b0;
                        stalled     <= 1'b0;
                        issue_count <= '0;
                        busy        <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (found) begin
                        line_idx    <= pick;
                        line_is_row <= (TW'(pick) < TW'(rows_q));
                        line_valid  <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        complete <= all_solved;
                        stalled  <= !all_solved;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ISSUE: begin
                    if (line_ready) begin
                        dirty      <= dirty & ~idx_onehot;
                        ptr        <= (ptr_next >= total) ? '0 : IW'(ptr_next);
                        if (issue_count != 16'hFFFF)
                            issue_count <= issue_count + 16'd1;
                        line_valid <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (done_valid) begin
                        dirty <= dirty | set_mask;
                        if (done_line_solved)
                            solved <= solved | idx_onehot;
                        state <= SCAN;
                    end else if (timeout_hit) begin
                        complete <= 1'b0;
                        stalled  <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
